// File: rtl/vec_recorder.sv
// Linear capture buffer that records cap_data vectors and replays them in capture order over a valid/ready stream.
// Optional VEC_RECORDER_OVF_EN adds an 8-bit saturating counter of dropped/ignored captures (ovf_cnt).
module vec_recorder #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cap_en,
  input  logic [WIDTH-1:0]         cap_data,
  input  logic                     start_dump,
  input  logic                     dump_ready,
  output logic                     dump_valid,
  output logic [WIDTH-1:0]         dump_data,
  output logic                     dump_last,
  output logic [$clog2(DEPTH):0]   count,
`ifdef VEC_RECORDER_OVF_EN
  output logic [7:0]               ovf_cnt,
`endif
  output logic                     full,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] ZERO  = '0;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DUMP = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    rd_idx;
  logic             cap_ok;
  logic [CW-1:0]    count_nxt;
  logic [CW-1:0]    rd_nxt;
  logic             dump_go;
  logic             xfer;

  assign full      = (count == DEPTH_C);
  assign busy      = (state != S_IDLE);
  assign cap_ok    = (state == S_IDLE) && cap_en && !full;
  assign count_nxt = count + (cap_ok ? ONE : ZERO);
  // A same-cycle capture counts toward the dump, so an empty buffer can still start.
  assign dump_go   = (state == S_IDLE) && start_dump && (count_nxt != ZERO);
  assign xfer      = dump_valid && dump_ready;
  assign rd_nxt    = rd_idx + ONE;

  always_ff @(posedge clk) begin
    if (cap_ok) mem[count[AW-1:0]] <= cap_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      count      <= '0;
      rd_idx     <= '0;
      dump_valid <= 1'b0;
      dump_last  <= 1'b0;
      dump_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          count <= count_nxt;
          if (dump_go) begin
            state      <= S_DUMP;
            rd_idx     <= '0;
            dump_valid <= 1'b1;
            dump_last  <= (count_nxt == ONE);
            dump_data  <= (count == ZERO) ? cap_data : mem[0];
          end
        end
        S_DUMP: begin
          if (xfer) begin
            if (dump_last) begin
              state      <= S_DONE;
              dump_valid <= 1'b0;
              dump_last  <= 1'b0;
            end else begin
              rd_idx    <= rd_nxt;
              dump_data <= mem[rd_nxt[AW-1:0]];
              dump_last <= ((rd_nxt + ONE) == count);
            end
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          count  <= '0;
          rd_idx <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef VEC_RECORDER_OVF_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_cnt <= '0;
    end else if (state == S_DONE) begin
      ovf_cnt <= '0;
    end else if (cap_en && !cap_ok) begin
      ovf_cnt <= sat_inc(ovf_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_vec_recorder.sv
// Scoreboard bench for vec_recorder: stimulus queues expected readout entries, a negedge monitor pops and compares them.
module tb_vec_recorder;

  localparam int WIDTH = 2;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cap_en = 1'b0;
  logic [WIDTH-1:0] cap_data = '0;
  logic             start_dump = 1'b0;
  logic             dump_ready = 1'b0;
  logic             dump_valid;
  logic [WIDTH-1:0] dump_data;
  logic             dump_last;
  logic [CW-1:0]    count;
  logic             full;
  logic             busy;
`ifdef VEC_RECORDER_OVF_EN
  logic [7:0]       ovf_cnt;
`endif

  vec_recorder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .cap_en     (cap_en),
    .cap_data   (cap_data),
    .start_dump (start_dump),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_data  (dump_data),
    .dump_last  (dump_last),
    .count      (count),
`ifdef VEC_RECORDER_OVF_EN
    .ovf_cnt    (ovf_cnt),
`endif
    .full       (full),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [WIDTH:0]   exp_q[$];
  logic             holding = 1'b0;
  logic [WIDTH-1:0] held_data = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic last, input logic [WIDTH-1:0] d);
    exp_q.push_back({last, d});
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  // Monitor: a transfer happens at the next posedge whenever valid&ready is seen here.
  always @(negedge clk) begin
    logic [WIDTH:0] e;
    if (rst === 1'b1 && dump_valid === 1'b1) begin
      if (holding) chk("hold_data", int'(dump_data), int'(held_data));
      if (dump_ready) begin
        holding = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: got data %0d with empty queue, required none", dump_data);
        end else begin
          e = exp_q.pop_front();
          chk("dump_data", int'(dump_data), int'(e[WIDTH-1:0]));
          chk("dump_last", int'(dump_last), int'(e[WIDTH]));
        end
      end else begin
        holding   = 1'b1;
        held_data = dump_data;
      end
    end else begin
      holding = 1'b0;
    end
  end

  initial begin
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int n;

    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(dump_valid), 0);
    chk("rst_last", int'(dump_last), 0);
    chk("rst_data", int'(dump_data), 0);
    @(negedge clk) rst = 1'b1;
    tick();

    // Two captures, then a dump with cap_en asserted during DUMP/DONE
    cap_en = 1'b1; cap_data = 2'b01; tick();
    cap_data = 2'b10; tick();
    cap_en = 1'b0;
    chk("cap2_count", int'(count), 2);
    chk("cap2_full", int'(full), 0);
    chk("cap2_busy", int'(busy), 0);
    push(1'b0, 2'b01);
    push(1'b1, 2'b10);
    start_dump = 1'b1; dump_ready = 1'b1; tick();
    start_dump = 1'b0; cap_en = 1'b1; cap_data = 2'b11;
    chk("dump_first_valid", int'(dump_valid), 1);
    chk("dump_busy", int'(busy), 1);
    tick();
    tick();
    cap_en = 1'b0;
    chk("done_busy", int'(busy), 1);
    chk("done_valid", int'(dump_valid), 0);
    chk("done_count", int'(count), 2);
    tick();
    chk("post_done_busy", int'(busy), 0);
    chk("post_done_count", int'(count), 0);
`ifdef VEC_RECORDER_OVF_EN
    chk("ovf_cleared", int'(ovf_cnt), 0);
`endif

    // Fill to DEPTH, ninth capture dropped
    for (int i = 0; i < 9; i++) begin
      cap_en = 1'b1; cap_data = 2'(i); tick();
    end
    cap_en = 1'b0;
    chk("fill_count", int'(count), 8);
    chk("fill_full", int'(full), 1);
`ifdef VEC_RECORDER_OVF_EN
    chk("fill_ovf", int'(ovf_cnt), 1);
`endif
    for (int i = 0; i < 8; i++) push(i == 7, 2'(i));

    // Dump with a stalling sink
    start_dump = 1'b1; dump_ready = 1'b0; tick();
    start_dump = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      dump_ready = pat[n % 4];
      tick();
      n++;
    end
    dump_ready = 1'b1;
    chk("stall_timeout", int'(busy), 0);
    chk("stall_count", int'(count), 0);
    chk("stall_full", int'(full), 0);

    // start_dump with empty buffer is ignored
    start_dump = 1'b1; tick();
    start_dump = 1'b0;
    chk("empty_busy", int'(busy), 0);
    chk("empty_valid", int'(dump_valid), 0);
    tick();
    chk("empty_busy2", int'(busy), 0);

    // Reset mid-dump of four entries
    for (int i = 0; i < 4; i++) begin
      cap_en = 1'b1; cap_data = 2'(3 - i); tick();
    end
    cap_en = 1'b0;
    chk("four_count", int'(count), 4);
    dump_ready = 1'b0;
    start_dump = 1'b1; tick();
    start_dump = 1'b0;
    tick();
    chk("mid_valid", int'(dump_valid), 1);
    chk("mid_data", int'(dump_data), 3);
    #2 rst = 1'b0;
    #1;
    chk("abort_valid", int'(dump_valid), 0);
    chk("abort_last", int'(dump_last), 0);
    chk("abort_data", int'(dump_data), 0);
    chk("abort_count", int'(count), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_full", int'(full), 0);
    @(negedge clk) rst = 1'b1;
    dump_ready = 1'b1;
    tick();
    start_dump = 1'b1; tick();
    start_dump = 1'b0;
    chk("abort_restart_busy", int'(busy), 0);
    chk("abort_restart_valid", int'(dump_valid), 0);

    // Capture and start in the same cycle on an empty buffer
    push(1'b1, 2'b10);
    cap_en = 1'b1; cap_data = 2'b10; start_dump = 1'b1; tick();
    cap_en = 1'b0; start_dump = 1'b0;
    chk("same_valid", int'(dump_valid), 1);
    chk("same_data", int'(dump_data), 2);
    chk("same_last", int'(dump_last), 1);
    wait_idle(20);

    // Capture and start together with one entry already stored
    cap_en = 1'b1; cap_data = 2'b01; tick();
    push(1'b0, 2'b01);
    push(1'b1, 2'b11);
    cap_data = 2'b11; start_dump = 1'b1; tick();
    cap_en = 1'b0; start_dump = 1'b0;
    wait_idle(20);
    chk("final_count", int'(count), 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
